// File: rtl/rx_frame_assembler.sv
// Frame assembler behind the max-channel decoder: serial bits -> length/payload/CRC-8 frames,
// payload bytes delivered through a small first-word-fall-through FIFO, per-frame status pulse.
module rx_frame_assembler #(
  parameter int MAX_LEN    = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 4095
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enClk,
  input  logic       synchro,
  input  logic       infoBit,
  input  logic       infoValid,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic       frame_done,
  output logic       frame_ok,
  output logic [2:0] err_code
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);

  localparam logic [2:0] ERR_OK     = 3'd0;
  localparam logic [2:0] ERR_CRC    = 3'd1;
  localparam logic [2:0] ERR_LEN    = 3'd2;
  localparam logic [2:0] ERR_OVF    = 3'd3;
  localparam logic [2:0] ERR_TOUT   = 3'd4;
  localparam logic [2:0] ERR_RESYNC = 3'd5;

  typedef enum logic [1:0] {IDLE, LEN, PAYLOAD, CRC} state_t;

  state_t          state, state_nxt;
  logic [2:0]      bit_cnt;
  logic [7:0]      byte_cnt;
  logic [TW-1:0]   tout;
  logic            ovf;
  logic [7:0]      shreg;
  logic [7:0]      len_r;
  logic [7:0]      crc;
  logic [7:0]      byte_w;
  logic            pay_last;

  logic            start, shift, byte_done, fifo_we, drop, tout_inc, done;
  logic [2:0]      done_err;

  logic [8:0]      mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            fifo_full, fifo_rd;
  logic [8:0]      head;

  function automatic logic [7:0] crc8_byte(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    c = c_in ^ d;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  assign byte_w   = {shreg[6:0], infoBit};
  assign pay_last = (byte_cnt == len_r - 8'd1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // synchro outranks everything else on a tick, including a coincident data bit
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    shift     = 1'b0;
    byte_done = 1'b0;
    fifo_we   = 1'b0;
    drop      = 1'b0;
    tout_inc  = 1'b0;
    done      = 1'b0;
    done_err  = ERR_OK;
    if (enClk) begin
      if (synchro) begin
        start     = 1'b1;
        state_nxt = LEN;
        if (state != IDLE) begin
          done     = 1'b1;
          done_err = ERR_RESYNC;
        end
      end else if (state != IDLE) begin
        if (infoValid) begin
          shift = 1'b1;
          if (bit_cnt == 3'd7) begin
            byte_done = 1'b1;
            case (state)
              LEN: begin
                if (byte_w == 8'd0 || byte_w > MAX_LEN_B) begin
                  done      = 1'b1;
                  done_err  = ERR_LEN;
                  state_nxt = IDLE;
                end else begin
                  state_nxt = PAYLOAD;
                end
              end
              PAYLOAD: begin
                fifo_we = ~fifo_full;
                drop    = fifo_full;
                if (pay_last) state_nxt = CRC;
              end
              CRC: begin
                done      = 1'b1;
                done_err  = ovf ? ERR_OVF : ((byte_w != crc) ? ERR_CRC : ERR_OK);
                state_nxt = IDLE;
              end
              default: state_nxt = IDLE;
            endcase
          end
        end else if (tout == TOUT_LAST) begin
          done      = 1'b1;
          done_err  = ERR_TOUT;
          state_nxt = IDLE;
        end else begin
          tout_inc = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      tout       <= '0;
      ovf        <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err_code   <= ERR_OK;
    end else begin
      frame_done <= done;
      frame_ok   <= done && (done_err == ERR_OK);
      if (done) err_code <= done_err;
      if (start) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
        tout     <= '0;
        ovf      <= 1'b0;
      end else if (shift) begin
        bit_cnt <= bit_cnt + 3'd1;
        tout    <= '0;
        if (byte_done && state == PAYLOAD) byte_cnt <= byte_cnt + 8'd1;
        if (drop) ovf <= 1'b1;
      end else if (tout_inc) begin
        tout <= tout + 1'b1;
      end
    end
  end

  // datapath registers carry no reset; a frame start re-seeds what matters
  always_ff @(posedge clk) begin
    if (start) crc <= 8'h00;
    else if (byte_done && state != CRC) crc <= crc8_byte(crc, byte_w);
    if (shift) shreg <= byte_w;
    if (byte_done && state == LEN) len_r <= byte_w;
  end

  // output FIFO; fullness is judged on the pre-read count
  assign fifo_full = ((wr_ptr - rd_ptr) == DEPTH_C);
  assign m_valid   = (wr_ptr != rd_ptr);
  assign fifo_rd   = m_valid & m_ready;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign m_data    = m_valid ? head[7:0] : 8'h00;
  assign m_last    = m_valid & head[8];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_we) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_we) mem[wr_ptr[AW-1:0]] <= {pay_last, byte_w};
  end

endmodule

// File: tb/tb_rx_frame_assembler.sv
// Bench for rx_frame_assembler: frame vectors from a table, hand-built corner sequences,
// and randomized frames checked against a byte-level queue model of the FIFO and frame status.
module tb_rx_frame_assembler;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst, enClk, synchro, infoBit, infoValid, m_ready;
  logic [7:0] m_data;
  logic       m_valid, m_last, frame_done, frame_ok;
  logic [2:0] err_code;

  rx_frame_assembler #(.MAX_LEN(64), .FIFO_DEPTH(DEPTH), .TIMEOUT(4095)) dut (
    .clk(clk), .rst(rst), .enClk(enClk), .synchro(synchro), .infoBit(infoBit),
    .infoValid(infoValid), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready), .frame_done(frame_done), .frame_ok(frame_ok), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [8:0] q[$];
  bit         exp_done;
  logic [2:0] last_err;
  bit         ovf_seen;
  int         rdy_mode;

  typedef struct {
    logic [7:0] b [4];
    int         n;
    int         err;
  } vec_t;
  vec_t vt [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // bit-serial CRC-8 (poly 0x07, init 0) as long division over the message bits
  function automatic logic [7:0] crc_of(input logic [7:0] d[$], input int n);
    logic [7:0] c;
    logic [7:0] cur;
    logic       fbk;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      cur = d[i];
      for (int k = 7; k >= 0; k--) begin
        fbk = c[7] ^ cur[k];
        c   = {c[6:0], 1'b0} ^ (fbk ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  // one clock: drive inputs, compare outputs mid-cycle, advance model at the edge
  task automatic tick(input bit en, input bit syn, input bit ib, input bit iv, input bit wr,
                      input logic [7:0] wb, input bit wl, input bit dn, input logic [2:0] de);
    bit rd, full;
    enClk = en; synchro = syn; infoBit = ib; infoValid = iv;
    m_ready = (rdy_mode == 0) ? 1'b0 : (rdy_mode == 1) ? 1'b1 : 1'($urandom % 2);
    @(negedge clk);
    chk("m_valid", m_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("m_data", m_data, q[0][7:0]);
      chk("m_last", m_last, q[0][8]);
    end
    chk("frame_done", frame_done, exp_done);
    chk("frame_ok", frame_ok, exp_done && last_err == 3'd0);
    chk("err_code", err_code, last_err);
    full = (q.size() == DEPTH);
    rd   = m_ready && q.size() > 0;
    if (rd) void'(q.pop_front());
    if (wr) begin
      if (!full) q.push_back({wl, wb});
      else ovf_seen = 1'b1;
    end
    exp_done = dn;
    if (dn) last_err = de;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 0, 0, 0, 8'h00, 0, 0, 3'd0);
  endtask

  task automatic gap();
    int n;
    n = $urandom % 3;
    repeat (n) tick(0, 1'($urandom), 1'($urandom), 1'($urandom), 0, 8'h00, 0, 0, 3'd0);
    if ($urandom % 4 == 0) tick(1, 0, 1'($urandom), 0, 0, 8'h00, 0, 0, 3'd0);
  endtask

  // force_err<0: status derived from frame contents; cut>=0: stop after that many bits
  task automatic send_frame(input logic [7:0] fb[$], input int force_err, input bit gaps,
                            input bit resync, input int cut);
    int         len, nb;
    bit         badlen, lastb, wr, dn;
    logic [2:0] de;
    logic [7:0] cur;
    len    = int'(fb[0]);
    badlen = (len == 0 || len > 64);
    ovf_seen = 1'b0;
    tick(1, 1, 1'($urandom % 2), 1'($urandom % 2), 0, 8'h00, 0, resync, 3'd5);
    nb = 0;
    for (int i = 0; i < fb.size(); i++) begin
      cur = fb[i];
      for (int k = 7; k >= 0; k--) begin
        if (cut >= 0 && nb >= cut) return;
        if (gaps) gap();
        lastb = (k == 0);
        wr = lastb && !badlen && i >= 1 && i <= len;
        dn = lastb && (badlen ? (i == 0) : (i == fb.size() - 1));
        if (badlen) de = 3'd2;
        else if (force_err >= 0) de = 3'(force_err);
        else de = ovf_seen ? 3'd3 : ((crc_of(fb, fb.size() - 1) != fb[fb.size() - 1]) ? 3'd1 : 3'd0);
        tick(1, 0, cur[k], 1, wr, cur, (i == len), dn, de);
        nb++;
        if (dn) return;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; enClk = 0; synchro = 0; infoBit = 0; infoValid = 0; m_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    q.delete(); exp_done = 0; last_err = 3'd0; ovf_seen = 0;
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_ok", frame_ok, 0);
    chk("rst_err_code", err_code, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] fb[$];
    logic [7:0] tmp[$];
    logic [7:0] c;
    int         len, kind, cnt;

    tmp = '{8'h01, 8'h7E};
    vt[0].b = '{8'h02, 8'hA5, 8'h3C, 8'h3B}; vt[0].n = 4; vt[0].err = 0;
    vt[1].b = '{8'h02, 8'hA5, 8'h3C, 8'h3A}; vt[1].n = 4; vt[1].err = 1;
    vt[2].b = '{8'h00, 8'h00, 8'h00, 8'h00}; vt[2].n = 1; vt[2].err = 2;
    vt[3].b = '{8'h41, 8'h00, 8'h00, 8'h00}; vt[3].n = 1; vt[3].err = 2;
    vt[4].b = '{8'h01, 8'h7E, crc_of(tmp, 2), 8'h00}; vt[4].n = 3; vt[4].err = 0;
    tmp = '{8'h01, 8'h00};
    vt[5].b = '{8'h01, 8'h00, crc_of(tmp, 2), 8'h00}; vt[5].n = 3; vt[5].err = 0;
    tmp = '{8'h40};
    vt[6].b = '{8'h01, 8'hFF, 8'h55, 8'h00}; vt[6].n = 3; vt[6].err = 1;

    rdy_mode = 1;
    do_reset();

    for (int v = 0; v < 7; v++) begin
      fb = {};
      for (int j = 0; j < vt[v].n; j++) fb.push_back(vt[v].b[j]);
      send_frame(fb, vt[v].err, 0, 0, -1);
      idle(3);
    end

    // FIFO overflow: 20 payload bytes with nobody reading
    rdy_mode = 0;
    fb = {8'd20};
    for (int j = 0; j < 20; j++) fb.push_back(8'(j * 7 + 1));
    fb.push_back(crc_of(fb, 21));
    send_frame(fb, 3, 0, 0, -1);
    idle(1);
    rdy_mode = 1;
    cnt = 0;
    while (m_valid && cnt < 40) begin
      idle(1);
      cnt++;
    end
    chk("ovf_held", cnt, 16);

    // timeout after 5 bits, then unsynchronised bits must be ignored
    fb = {8'h03, 8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(fb, 0, 0, 0, 5);
    for (int i = 1; i <= 4095; i++) tick(1, 0, 0, 0, 0, 8'h00, 0, i == 4095, 3'd4);
    idle(1);
    for (int i = 0; i < 24; i++) tick(1, 0, 1'($urandom), 1, 0, 8'h00, 0, 0, 3'd0);
    idle(2);

    // resync mid-payload, then a clean short frame
    fb = {8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h00};
    send_frame(fb, 0, 0, 0, 24);
    tmp = '{8'h01, 8'h7E};
    fb = {8'h01, 8'h7E, crc_of(tmp, 2)};
    send_frame(fb, 0, 0, 1, -1);
    idle(3);

    // reset mid-frame with bytes held: flushed, no status pulse
    rdy_mode = 0;
    fb = {8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    send_frame(fb, 0, 0, 0, 24);
    do_reset();
    idle(2);
    rdy_mode = 1;
    tmp = '{8'h01, 8'h5A};
    fb = {8'h01, 8'h5A, crc_of(tmp, 2)};
    send_frame(fb, 0, 0, 0, -1);
    idle(2);

    // randomized frames with gaps, frozen ticks and random back-pressure
    rdy_mode = 2;
    for (int f = 0; f < 20; f++) begin
      kind = $urandom % 8;
      if (kind == 0) len = ($urandom % 2) ? 0 : 65 + $urandom % 100;
      else len = 1 + $urandom % 40;
      fb = {8'(len)};
      if (len >= 1 && len <= 64) begin
        for (int j = 0; j < len; j++) fb.push_back(8'($urandom));
        c = crc_of(fb, fb.size());
        if (kind == 1) c = c ^ (8'h01 << ($urandom % 8));
        fb.push_back(c);
      end
      send_frame(fb, -1, 1, 0, -1);
      idle(1 + $urandom % 4);
    end

    rdy_mode = 1;
    cnt = 0;
    while (q.size() > 0 && cnt < 100) begin
      idle(1);
      cnt++;
    end
    idle(1);
    chk("drain_empty", m_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
